// File: rtl/k_sync_fifo_t2.sv
`default_nettype none
// ============================================================================
// Module   : k_sync_fifo_t2
// Purpose  : Single-clock FIFO with occupancy count, almost-full/empty
//            thresholds, sticky overflow/underflow and synchronous flush.
//            Read side is either registered (FWFT=0) or fall-through (FWFT=1).
// Revision : 1.0  initial release
// ============================================================================
module k_sync_fifo_t2 #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4,
   parameter int FWFT      = 0,
   parameter int AF_TH     = 12,
   parameter int AE_TH     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic [DATA_SIZE-1:0] wdata,
   input  logic                 wput,
   output logic                 wfull,
   output logic                 walmost_full,
   input  logic                 rget,
   output logic [DATA_SIZE-1:0] rdata,
   output logic                 rvalid,
   output logic                 rempty,
   output logic                 ralmost_empty,
   output logic [ADDR_SIZE:0]   count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int               c_DEPTH = 2**ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] c_FULL = c_DEPTH[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] c_AF   = AF_TH[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] c_AE   = AE_TH[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] c_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};

   logic [ADDR_SIZE:0]   wptr_q, wptr_d;
   logic [ADDR_SIZE:0]   rptr_q, rptr_d;
   logic [ADDR_SIZE:0]   count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   logic [DATA_SIZE-1:0] mem_q [c_DEPTH];

   logic                 w_full;
   logic                 w_empty;
   logic                 wr_acc;
   logic                 rd_acc;
   logic [ADDR_SIZE-1:0] waddr;
   logic [ADDR_SIZE-1:0] raddr;

   assign w_full  = (count_q == c_FULL);
   assign w_empty = (count_q == '0);
   assign waddr   = wptr_q[ADDR_SIZE-1:0];
   assign raddr   = rptr_q[ADDR_SIZE-1:0];

   // A flush cycle suppresses both accesses entirely.
   assign wr_acc = wput & ~w_full  & ~clr;
   assign rd_acc = rget & ~w_empty & ~clr;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + c_ONE;
         if (rd_acc) rptr_d = rptr_q + c_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + c_ONE;
            2'b01:   count_d = count_q - c_ONE;
            default: count_d = count_q;
         endcase
         if (wput & w_full)  ovf_d = 1'b1;
         if (rget & w_empty) unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[waddr] <= wdata;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rdata  = mem_q[raddr];
         assign rvalid = ~w_empty;
      end else begin : g_std
         logic [DATA_SIZE-1:0] rdata_q;
         logic                 rvalid_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= rd_acc;
               if (rd_acc) rdata_q <= mem_q[raddr];
            end
         end
         assign rdata  = rdata_q;
         assign rvalid = rvalid_q;
      end
   endgenerate

   assign wfull         = w_full;
   assign rempty        = w_empty;
   assign walmost_full  = (count_q >= c_AF);
   assign ralmost_empty = (count_q <= c_AE);
   assign count         = count_q;
   assign overflow      = ovf_q;
   assign underflow     = unf_q;

   // Pointer distance must agree with the count-derived full flag.
   a_full_consistent : assert property (@(posedge clk) disable iff (rst)
      w_full == ((wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) && (waddr == raddr)));

endmodule
`default_nettype wire

// File: tb/tb_k_sync_fifo_t2.sv
`default_nettype none
// ============================================================================
// Module   : tb_k_sync_fifo_t2
// Purpose  : Scoreboard bench driving a registered and a fall-through FIFO
//            with identical stimulus against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_k_sync_fifo_t2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic [7:0] wdata = '0;
   logic       wput = 1'b0;
   logic       rget = 1'b0;

   logic       wfull_s, waf_s, rvalid_s, rempty_s, rae_s, ovf_s, unf_s;
   logic [7:0] rdata_s;
   logic [4:0] count_s;
   logic       wfull_f, waf_f, rvalid_f, rempty_f, rae_f, ovf_f, unf_f;
   logic [7:0] rdata_f;
   logic [4:0] count_f;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] m_q[$];
   logic [7:0] exp_std[$];
   bit         m_ovf = 0, m_unf = 0, m_rv = 0;
   logic [7:0] m_last = '0;

   always #5 clk = ~clk;

   k_sync_fifo_t2 #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(0), .AF_TH(12), .AE_TH(2)) u_std (
      .clk(clk), .rst(rst), .clr(clr), .wdata(wdata), .wput(wput),
      .wfull(wfull_s), .walmost_full(waf_s), .rget(rget), .rdata(rdata_s),
      .rvalid(rvalid_s), .rempty(rempty_s), .ralmost_empty(rae_s),
      .count(count_s), .overflow(ovf_s), .underflow(unf_s));

   k_sync_fifo_t2 #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(1), .AF_TH(12), .AE_TH(2)) u_fw (
      .clk(clk), .rst(rst), .clr(clr), .wdata(wdata), .wput(wput),
      .wfull(wfull_f), .walmost_full(waf_f), .rget(rget), .rdata(rdata_f),
      .rvalid(rvalid_f), .rempty(rempty_f), .ralmost_empty(rae_f),
      .count(count_f), .overflow(ovf_f), .underflow(unf_f));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      exp_std.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_last = '0;
   endtask

   // One clock: apply inputs, advance the model, return just after the falling edge.
   task automatic cycle(input bit w, input bit r, input bit c, input logic [7:0] d);
      bit full, empty;
      wput = w; rget = r; clr = c; wdata = d;
      if (c) begin
         m_q.delete();
         m_ovf = 0; m_unf = 0; m_rv = 0;
      end else begin
         full  = (m_q.size() == 16);
         empty = (m_q.size() == 0);
         if (w && full)  m_ovf = 1;
         if (r && empty) m_unf = 1;
         m_rv = r && !empty;
         if (m_rv) begin
            m_last = m_q.pop_front();
            exp_std.push_back(m_last);
         end
         if (w && !full) m_q.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      wput = 0; rget = 0; clr = 0;
   endtask

   // Monitor: compares DUT state with the model on every falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         int n;
         n = m_q.size();
         chk("count_std", count_s, n);
         chk("count_fwft", count_f, n);
         chk("wfull", wfull_s, n == 16);
         chk("rempty", rempty_s, n == 0);
         chk("walmost_full", waf_s, n >= 12);
         chk("ralmost_empty", rae_s, n <= 2);
         chk("overflow", ovf_s, m_ovf);
         chk("underflow", unf_s, m_unf);
         chk("fwft_flags", {wfull_f, rempty_f, waf_f, rae_f, ovf_f, unf_f},
             {n == 16, n == 0, n >= 12, n <= 2, m_ovf, m_unf});
         chk("rvalid_std", rvalid_s, m_rv);
         chk("rvalid_fwft", rvalid_f, n != 0);
         chk("rdata_hold_std", rdata_s, m_last);
         if (rvalid_s) begin
            if (exp_std.size() == 0) chk("sb_std_unexpected", 1, 0);
            else chk("sb_rdata_std", rdata_s, exp_std.pop_front());
         end
         if (n != 0) chk("rdata_fwft", rdata_f, m_q[0]);
      end
   end

   initial begin
      #1;
      chk("rst_count", count_s, 0);
      chk("rst_flags", {rempty_s, wfull_s, rae_s, waf_s, ovf_s, unf_s, rvalid_s}, 7'b1010000);
      chk("rst_rdata", rdata_s, 0);
      @(negedge clk); #1;
      rst = 0;

      // Fill, then one write too many
      for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'(i));
      cycle(1, 0, 0, 8'hFF);
      // Drain, then one read too many
      for (int i = 0; i < 17; i++) cycle(0, 1, 0, 8'h00);
      cycle(0, 0, 1, 8'h00);

      // Single word through an empty FIFO
      cycle(1, 0, 0, 8'hA5);
      cycle(0, 0, 0, 8'h00);
      cycle(0, 1, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);

      // Simultaneous access at empty, full, and mid-level
      cycle(1, 1, 0, 8'h11);
      cycle(0, 0, 1, 8'h00);
      for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'(8'h40 + i));
      cycle(1, 1, 0, 8'h22);
      cycle(0, 0, 1, 8'h00);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'(8'h60 + i));
      cycle(1, 1, 0, 8'h33);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00);
      cycle(0, 0, 1, 8'h00);

      // Wrap-around with interleaved pairs
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0, 0, 8'($urandom));
         cycle(0, 1, 0, 8'h00);
      end

      // Random traffic with varying fill bias and rare flushes
      for (int i = 0; i < 400; i++) begin
         int wp;
         wp = ((i / 50) % 2 == 0) ? 75 : 30;
         cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp - 10,
               $urandom_range(0, 59) == 0, 8'($urandom));
      end
      cycle(0, 0, 1, 8'h00);

      // Flush at count 9 with overflow pending; flush-cycle write must be ignored
      for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'(8'h80 + i));
      cycle(1, 0, 0, 8'hEE);
      for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'h00);
      chk("pre_flush_count", count_s, 9);
      cycle(1, 0, 1, 8'hDD);
      cycle(1, 0, 0, 8'h5A);
      cycle(0, 1, 0, 8'h00);

      // Asynchronous reset between edges
      for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'(8'hC0 + i));
      cycle(1, 1, 0, 8'h00);
      rst = 1;
      #1;
      chk("arst_count", count_s, 0);
      chk("arst_count_fwft", count_f, 0);
      chk("arst_flags", {rempty_s, wfull_s, rae_s, waf_s, ovf_s, unf_s, rvalid_s}, 7'b1010000);
      chk("arst_rdata", rdata_s, 0);
      model_reset();
      #1;
      rst = 0;
      cycle(1, 0, 0, 8'h77);
      cycle(0, 1, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
